// File: rtl/pe_bitserial_accumulator.sv
// Bit-serial accumulation PE: LSB-first full adder built from two half adders,
// summing a handshaked operand stream into an ACC_W-bit total.
module pe_bitserial_accumulator #(
  parameter int DIN_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = (ACC_W > 1) ? $clog2(ACC_W) : 1;

  if (ACC_W < DIN_W) begin : g_width_chk
    $error("ACC_W must be >= DIN_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [ACC_W-1:0] op_sr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             ovf;
  logic             last_q;
  logic             last_bit;

  logic ha0_s, ha0_c;
  logic ha1_s, ha1_c;
  logic cout;

  assign ha0_s = acc[0] ^ op_sr[0];
  assign ha0_c = acc[0] & op_sr[0];
  assign ha1_s = ha0_s ^ c;
  assign ha1_c = ha0_s & c;
  assign cout  = ha0_c | ha1_c;

  // Sum bit enters at the MSB; after ACC_W shifts acc is back in place.
  assign acc_nx   = (acc >> 1) | (ACC_W'(ha1_s) << (ACC_W - 1));
  assign last_bit = (cnt == CW'(ACC_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = ADD;
      end
      ADD: begin
        if (last_bit) state_nx = last_q ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      op_sr  <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      ovf    <= 1'b0;
      last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_sr  <= ACC_W'(in_data);
            c      <= 1'b0;
            cnt    <= '0;
            last_q <= in_last;
          end
        end
        ADD: begin
          acc   <= acc_nx;
          op_sr <= op_sr >> 1;
          c     <= cout;
          cnt   <= cnt + 1'b1;
          if (last_bit) ovf <= ovf | cout;
        end
        DONE: begin
          if (out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? acc : '0;
  assign out_ovf  = out_valid & ovf;

endmodule

// File: tb/tb_pe_bitserial_accumulator.sv
// Directed + table + random checks of pe_bitserial_accumulator,
// with a 16-bit and an 8-bit accumulator instance.
module tb_pe_bitserial_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic v16, v8, r16, r8;
  logic ir16, ir8, ov16, ov8, of16, of8;
  logic [15:0] od16;
  logic [7:0]  od8;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_data;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  logic [7:0] ops_q[$];

  typedef struct {
    logic        sel;
    logic [7:0]  ops[4];
    int          n;
    logic [15:0] ed;
    logic        eo;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v16 = in_valid & ~sel;
  assign v8  = in_valid & sel;
  assign r16 = out_ready & ~sel;
  assign r8  = out_ready & sel;

  assign in_ready  = sel ? ir8 : ir16;
  assign out_valid = sel ? ov8 : ov16;
  assign out_ovf   = sel ? of8 : of16;
  assign out_data  = sel ? {8'd0, od8} : od16;

  pe_bitserial_accumulator #(.DIN_W(8), .ACC_W(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(ir16),
    .in_data(in_data), .in_last(in_last),
    .out_valid(ov16), .out_ready(r16),
    .out_data(od16), .out_ovf(of16)
  );

  pe_bitserial_accumulator #(.DIN_W(8), .ACC_W(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(ir8),
    .in_data(in_data), .in_last(in_last),
    .out_valid(ov8), .out_ready(r8),
    .out_data(od8), .out_ovf(of8)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic s, input int n,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic [15:0] ed, input logic eo);
    vec_t v;
    v.sel = s;
    v.n = n;
    v.ops[0] = a;
    v.ops[1] = b;
    v.ops[2] = c;
    v.ops[3] = d;
    v.ed = ed;
    v.eo = eo;
    vt.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic l, output int tacc);
    int t;
    t = 0;
    tacc = -1;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      tacc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic wait_result(output int tv, output bit ok);
    int t;
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    ok = out_valid;
    tv = cyc;
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic run_sum(input string nm, input logic [15:0] ed,
                         input logic eo, input bit timing);
    int gap, ta, tp, tv;
    bit ok;
    gap = sel ? 9 : 17;
    tp = 0;
    for (int i = 0; i < ops_q.size(); i++) begin
      send(ops_q[i], i == ops_q.size() - 1, ta);
      if (timing && i > 0) chk({nm, "_gap"}, ta - tp, gap);
      tp = ta;
    end
    in_valid = 1'b0;
    wait_result(tv, ok);
    if (ok) begin
      if (timing) chk({nm, "_lat"}, tv - tp, gap);
      chk({nm, "_data"}, out_data, ed);
      chk({nm, "_ovf"}, out_ovf, eo);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int sum, n, mask;
    rst_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    add_vec(0, 1,   5,   0,   0,   0, 16'd5,     0);
    add_vec(0, 3, 100, 200, 255,   0, 16'h022B,  0);
    add_vec(1, 2, 200, 100,   0,   0, 16'd44,    1);
    add_vec(1, 1,   1,   0,   0,   0, 16'd1,     0);
    add_vec(0, 1,   0,   0,   0,   0, 16'd0,     0);
    add_vec(0, 4, 255, 255, 255, 255, 16'h03FC,  0);
    add_vec(1, 2, 255,   1,   0,   0, 16'd0,     1);
    add_vec(1, 2, 128, 127,   0,   0, 16'd255,   0);
    add_vec(1, 4, 255, 255, 255, 255, 16'd252,   1);

    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ovf", out_ovf, 0);
    end
    @(negedge clk);

    foreach (vt[i]) begin
      sel = vt[i].sel;
      ops_q.delete();
      for (int k = 0; k < vt[i].n; k++) ops_q.push_back(vt[i].ops[k]);
      run_sum($sformatf("vec%0d", i), vt[i].ed, vt[i].eo, 1'b1);
    end

    // Result held under back-pressure, then released.
    begin
      int ta, tv;
      bit ok;
      sel = 1'b0;
      send(8'd42, 1'b1, ta);
      in_valid = 1'b0;
      wait_result(tv, ok);
      for (int k = 0; k < 10; k++) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 42);
        chk("hold_ovf", out_ovf, 0);
        chk("hold_in_ready", in_ready, 0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rel_valid", out_valid, 0);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_data", out_data, 0);
    end

    // 258 x 255 wraps the 16-bit accumulator once.
    sel = 1'b0;
    ops_q.delete();
    repeat (258) ops_q.push_back(8'd255);
    run_sum("wrap16", 16'd254, 1'b1, 1'b0);

    // Reset in the middle of the second operand's add phase.
    begin
      int ta;
      send(8'd3, 1'b0, ta);
      send(8'd9, 1'b0, ta);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_data", out_data, 0);
      chk("abort_ovf", out_ovf, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ops_q.delete();
      ops_q.push_back(8'd7);
      run_sum("abort_fresh", 16'd7, 1'b0, 1'b1);
    end

    for (int r = 0; r < 16; r++) begin
      sel = (r >= 10);
      mask = sel ? 255 : 65535;
      n = $urandom_range(1, 20);
      sum = 0;
      ops_q.delete();
      for (int k = 0; k < n; k++) begin
        ops_q.push_back(8'($urandom_range(0, 255)));
        sum += ops_q[k];
      end
      run_sum($sformatf("rand%0d", r), 16'(sum & mask), sum > mask, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
